// File: rtl/end_sequencer_if.sv
// end_sequencer_if
//   Groups the control and timeline signals exchanged between the game logic,
//   the End_timeline lookup table and the end-of-game sequencer.
//   Signals:
//     start        1-cycle request to (re)start the sequence
//     abort        force the sequencer back to idle
//     end_counter  step index presented to the End_timeline table
//     end_now      frame code returned by the table (combinational on end_counter)
//     frame_code   registered frame code for the display/sound stage
//     busy         high while the sequence is running
//     done         1-cycle pulse when the sequence finishes
//   Modports:
//     slave   sequencer view
//     master  game FSM / table / downstream view
interface end_sequencer_if;
  logic       start;
  logic       abort;
  logic [5:0] end_counter;
  logic [3:0] end_now;
  logic [3:0] frame_code;
  logic       busy;
  logic       done;

  modport slave (
    input  start, abort, end_now,
    output end_counter, frame_code, busy, done
  );

  modport master (
    output start, abort, end_now,
    input  end_counter, frame_code, busy, done
  );
endinterface

// File: rtl/end_sequencer.sv
// end_sequencer
//   Steps a 6-bit frame counter once every TICK_DIV clocks, presents it to the
//   End_timeline table, registers the returned frame code and pulses done when the
//   terminal code appears (or when the step limit is reached).
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    end_sequencer_if.slave (start, abort, end_now in;
//            end_counter, frame_code, busy, done out)
//   All outputs come straight from registers.
module end_sequencer #(
  parameter int unsigned TICK_DIV = 10_000_000,
  parameter logic [3:0]  END_CODE = 4'd4,
  parameter logic [5:0]  MAX_STEP = 6'd63
) (
  input  logic           clk,
  input  logic           rst_n,
  end_sequencer_if.slave bus
);

  localparam int unsigned      PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [PW-1:0] pre_r, pre_nxt_s;
  logic [5:0]    cnt_r, cnt_nxt_s;
  logic [3:0]    fc_r, fc_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic          done_r, done_nxt_s;
  logic          tick_s;
  logic          exit_s;

  // Last cycle of the current step, and the RUN termination condition.
  assign tick_s = (pre_r == PRE_LAST);
  assign exit_s = (bus.end_now == END_CODE) || ((cnt_r == MAX_STEP) && tick_s);

  // Next-state and next-output decode; abort takes priority over start everywhere.
  always_comb begin
    state_nxt_s = state_r;
    pre_nxt_s   = pre_r;
    cnt_nxt_s   = cnt_r;
    fc_nxt_s    = fc_r;
    busy_nxt_s  = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pre_nxt_s = '0;
        cnt_nxt_s = 6'd0;
        fc_nxt_s  = 4'd0;
        if (!bus.abort && bus.start) begin
          state_nxt_s = ST_RUN;
          busy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
          pre_nxt_s   = '0;
          cnt_nxt_s   = 6'd0;
          fc_nxt_s    = 4'd0;
        end else if (exit_s) begin
          // Counter freezes on the exit step; the last code is captured with done.
          state_nxt_s = ST_HOLD;
          pre_nxt_s   = '0;
          fc_nxt_s    = bus.end_now;
          done_nxt_s  = 1'b1;
        end else begin
          busy_nxt_s = 1'b1;
          fc_nxt_s   = bus.end_now;
          if (tick_s) begin
            pre_nxt_s = '0;
            // Saturate rather than wrap at the step limit.
            if (cnt_r != MAX_STEP) begin
              cnt_nxt_s = cnt_r + 6'd1;
            end else begin
              cnt_nxt_s = cnt_r;
            end
          end else begin
            pre_nxt_s = pre_r + PW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
          pre_nxt_s   = '0;
          cnt_nxt_s   = 6'd0;
          fc_nxt_s    = 4'd0;
        end else if (bus.start) begin
          // Restart from step 0 with a clean frame code.
          state_nxt_s = ST_RUN;
          busy_nxt_s  = 1'b1;
          pre_nxt_s   = '0;
          cnt_nxt_s   = 6'd0;
          fc_nxt_s    = 4'd0;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        pre_nxt_s   = '0;
        cnt_nxt_s   = 6'd0;
        fc_nxt_s    = 4'd0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pre_r   <= '0;
      cnt_r   <= 6'd0;
      fc_r    <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pre_r   <= pre_nxt_s;
      cnt_r   <= cnt_nxt_s;
      fc_r    <= fc_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign bus.end_counter = cnt_r;
  assign bus.frame_code  = fc_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule
